// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control sequencer: opcodes, funct codes,
// ALU operation codes, FSM state encoding and the decoded control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_HALT = 2'd3
  } state_e;

  // Datapath control lines for one instruction, as seen in EXEC.
  typedef struct packed {
    logic       pc_en;
    logic       jump;
    logic       branch;
    logic       wr;
    logic       alu_src_b;
    logic       reg_dst;
    logic       memtoreg;
    logic [2:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/mips_main_decoder.sv
// Purely combinational opcode/funct decode. Produces the EXEC-cycle control
// bundle plus classification flags; the sequencer gates everything by state.
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       is_mem_o,
  output logic       is_store_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  // Decode table; anything unrecognised yields all-zero controls + illegal.
  always_comb begin
    ctrl_o       = '0;
    is_mem_o     = 1'b0;
    is_store_o   = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst = 1'b1;
        ctrl_o.wr      = 1'b1;
        ctrl_o.pc_en   = 1'b1;
        unique case (funct_i)
          FN_ADD:  ctrl_o.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl_o.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl_o.alu_ctrl = ALU_AND;
          FN_OR:   ctrl_o.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl_o.alu_ctrl = ALU_SLT;
          default: begin
            ctrl_o       = '0;
            is_illegal_o = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.alu_ctrl  = ALU_ADD;
        ctrl_o.wr        = 1'b1;
        ctrl_o.pc_en     = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.alu_ctrl = ALU_SUB;
        ctrl_o.pc_en    = 1'b1;
      end
      OP_J: begin
        ctrl_o.jump  = 1'b1;
        ctrl_o.pc_en = 1'b1;
      end
      OP_LW, OP_SW: begin
        // Address computation only; PC advances when memory acks.
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.alu_ctrl  = ALU_ADD;
        is_mem_o         = 1'b1;
        is_store_o       = (opcode_i == OP_SW);
      end
      OP_HALT: is_halt_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Control sequencer for the single-cycle MIPS datapath: IDLE/EXEC/MEM/HALT
// FSM, data-memory req/ack stretching for lw/sw, sticky illegal flag and a
// retired-instruction counter. Define MIPS_SEQ_CTRL_MEM_TIMEOUT_EN to build
// the MEM-state watchdog; otherwise timeout is tied 0 and MEM waits forever.
module mips_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             jump,
  output logic             branch,
  output logic             wr,
  output logic             alu_src_b,
  output logic             reg_dst,
  output logic             memtoreg,
  output logic [2:0]       alu_ctrl,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_t  dec_ctrl;
  logic   dec_mem, dec_store, dec_halt, dec_illegal;

  state_e           state_q, state_d;
  logic             store_q, store_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctl;
  logic             mem_req_s, mem_we_s;

  mips_main_decoder u_dec (
    .opcode_i     (opcode),
    .funct_i      (funct),
    .ctrl_o       (dec_ctrl),
    .is_mem_o     (dec_mem),
    .is_store_o   (dec_store),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_illegal)
  );

`ifdef MIPS_SEQ_CTRL_MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  // Next-state and Moore-gated control outputs; IDLE/HALT drive nothing.
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    illegal_d = illegal_q;
    ctl       = '0;
    mem_req_s = 1'b0;
    mem_we_s  = 1'b0;
`ifdef MIPS_SEQ_CTRL_MEM_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: if (start) state_d = S_EXEC;
      S_EXEC: begin
        ctl = dec_ctrl;
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_mem) begin
          state_d = S_MEM;
          store_d = dec_store;
`ifdef MIPS_SEQ_CTRL_MEM_TIMEOUT_EN
          tmo_d   = TW'(MEM_TIMEOUT);
`endif
        end
      end
      S_MEM: begin
        // Address operands stay selected while the PC is frozen.
        ctl.alu_src_b = 1'b1;
        ctl.alu_ctrl  = ALU_ADD;
        mem_req_s     = 1'b1;
        mem_we_s      = store_q;
        if (mem_ack) begin
          ctl.pc_en    = 1'b1;
          ctl.wr       = ~store_q;
          ctl.memtoreg = ~store_q;
          state_d      = S_EXEC;
        end
`ifdef MIPS_SEQ_CTRL_MEM_TIMEOUT_EN
        // Ack on the expiry cycle takes priority over the watchdog.
        else if (tmo_q <= TW'(1)) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
`endif
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
    cnt_d = cnt_q + CNT_W'(ctl.pc_en);
  end

  // State, sticky flags and retired counter; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      store_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef MIPS_SEQ_CTRL_MEM_TIMEOUT_EN
  // Watchdog down-counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign pc_en       = ctl.pc_en;
  assign jump        = ctl.jump;
  assign branch      = ctl.branch;
  assign wr          = ctl.wr;
  assign alu_src_b   = ctl.alu_src_b;
  assign reg_dst     = ctl.reg_dst;
  assign memtoreg    = ctl.memtoreg;
  assign alu_ctrl    = ctl.alu_ctrl;
  assign mem_req     = mem_req_s;
  assign mem_we      = mem_we_s;
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed bench for mips_seq_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are sampled 1 unit later, away from the edge.
module tb_mips_seq_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic [5:0]    funct = 6'd0;
  logic          mem_ack = 1'b0;
  logic          pc_en, jump, branch, wr, alu_src_b, reg_dst, memtoreg;
  logic [2:0]    alu_ctrl;
  logic          mem_req, mem_we, halted, illegal, timeout;
  logic [CW-1:0] instr_count;

  int n_pass = 0;
  int n_total = 0;

  mips_seq_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
    .mem_ack(mem_ack), .pc_en(pc_en), .jump(jump), .branch(branch), .wr(wr),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .memtoreg(memtoreg),
    .alu_ctrl(alu_ctrl), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .illegal(illegal), .timeout(timeout),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {pc_en,jump,branch,wr,alu_src_b,reg_dst,memtoreg,alu_ctrl,mem_req,mem_we,halted,illegal,timeout}
  wire [14:0] ctl = {pc_en, jump, branch, wr, alu_src_b, reg_dst, memtoreg,
                     alu_ctrl, mem_req, mem_we, halted, illegal, timeout};

  localparam logic [14:0] C_ZERO  = 15'b0_0_0_0_0_0_0_000_0_0_0_0_0;
  localparam logic [14:0] C_ADD   = 15'b1_0_0_1_0_1_0_010_0_0_0_0_0;
  localparam logic [14:0] C_SUB   = 15'b1_0_0_1_0_1_0_110_0_0_0_0_0;
  localparam logic [14:0] C_AND   = 15'b1_0_0_1_0_1_0_000_0_0_0_0_0;
  localparam logic [14:0] C_OR    = 15'b1_0_0_1_0_1_0_001_0_0_0_0_0;
  localparam logic [14:0] C_SLT   = 15'b1_0_0_1_0_1_0_111_0_0_0_0_0;
  localparam logic [14:0] C_ADDI  = 15'b1_0_0_1_1_0_0_010_0_0_0_0_0;
  localparam logic [14:0] C_LSEX  = 15'b0_0_0_0_1_0_0_010_0_0_0_0_0;
  localparam logic [14:0] C_LWWT  = 15'b0_0_0_0_1_0_0_010_1_0_0_0_0;
  localparam logic [14:0] C_LWACK = 15'b1_0_0_1_1_0_1_010_1_0_0_0_0;
  localparam logic [14:0] C_SWWT  = 15'b0_0_0_0_1_0_0_010_1_1_0_0_0;
  localparam logic [14:0] C_SWACK = 15'b1_0_0_0_1_0_0_010_1_1_0_0_0;
  localparam logic [14:0] C_BEQ   = 15'b1_0_1_0_0_0_0_110_0_0_0_0_0;
  localparam logic [14:0] C_J     = 15'b1_1_0_0_0_0_0_000_0_0_0_0_0;
  localparam logic [14:0] C_HALT  = 15'b0_0_0_0_0_0_0_000_0_0_1_0_0;
  localparam logic [14:0] C_ILL   = 15'b0_0_0_0_0_0_0_000_0_0_1_1_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: apply inputs, sample controls, advance past the edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic st, input logic ack, input logic [14:0] exp);
    opcode = op; funct = fn; start = st; mem_ack = ack;
    #1;
    chk(tag, {17'd0, ctl}, {17'd0, exp});
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ctl", {17'd0, ctl}, {17'd0, C_ZERO});
    chk("rst_cnt", {28'd0, instr_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    cyc("idle_start", 6'h00, 6'h00, 1'b1, 1'b0, C_ZERO);
    cyc("add", 6'b000000, 6'b100000, 1'b0, 1'b0, C_ADD);
    chk("cnt_add", {28'd0, instr_count}, 32'd1);
    cyc("sub", 6'b000000, 6'b100010, 1'b0, 1'b0, C_SUB);
    cyc("and", 6'b000000, 6'b100100, 1'b0, 1'b0, C_AND);
    cyc("or",  6'b000000, 6'b100101, 1'b0, 1'b0, C_OR);
    cyc("slt", 6'b000000, 6'b101010, 1'b0, 1'b0, C_SLT);
    cyc("addi", 6'b001000, 6'h00, 1'b0, 1'b0, C_ADDI);
    chk("cnt_alu", {28'd0, instr_count}, 32'd6);

    // lw: EXEC, 3 wait cycles, ack cycle = 5 cycles
    cyc("lw_exec", 6'b100011, 6'h00, 1'b0, 1'b0, C_LSEX);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 6'b100011, 6'h00, 1'b0, 1'b0, C_LWWT);
    chk("cnt_lw_hold", {28'd0, instr_count}, 32'd6);
    cyc("lw_ack", 6'b100011, 6'h00, 1'b0, 1'b1, C_LWACK);
    chk("cnt_lw", {28'd0, instr_count}, 32'd7);

    // sw: ack raised in EXEC must be ignored, then immediate ack in MEM
    cyc("sw_exec", 6'b101011, 6'h00, 1'b0, 1'b1, C_LSEX);
    cyc("sw_ack", 6'b101011, 6'h00, 1'b0, 1'b1, C_SWACK);
    chk("cnt_sw", {28'd0, instr_count}, 32'd8);

    cyc("beq", 6'b000100, 6'h00, 1'b0, 1'b0, C_BEQ);
    cyc("j", 6'b000010, 6'h00, 1'b0, 1'b0, C_J);
    cyc("halt_exec", 6'b111111, 6'h00, 1'b0, 1'b0, C_ZERO);
    cyc("halt_start", 6'b000000, 6'b100000, 1'b1, 1'b1, C_HALT);
    cyc("halt_stay", 6'b000000, 6'b100000, 1'b0, 1'b0, C_HALT);
    chk("cnt_halt", {28'd0, instr_count}, 32'd10);

    // Illegal opcode
    do_reset();
    chk("rst2_cnt", {28'd0, instr_count}, 32'd0);
    cyc("start2", 6'h00, 6'h00, 1'b1, 1'b0, C_ZERO);
    cyc("ill_op", 6'b010101, 6'h00, 1'b0, 1'b0, C_ZERO);
    cyc("ill_halt", 6'b000000, 6'b100000, 1'b0, 1'b0, C_ILL);
    chk("ill_cnt", {28'd0, instr_count}, 32'd0);

    // Unlisted R-type funct; reset must clear the sticky flag
    do_reset();
    chk("ill_clr", {31'd0, illegal}, 32'd0);
    cyc("start3", 6'h00, 6'h00, 1'b1, 1'b0, C_ZERO);
    cyc("ill_fn", 6'b000000, 6'b000000, 1'b0, 1'b0, C_ZERO);
    cyc("ill_fn_halt", 6'b000000, 6'b100000, 1'b0, 1'b0, C_ILL);

    // Counter wrap at 2^CW
    do_reset();
    cyc("start4", 6'h00, 6'h00, 1'b1, 1'b0, C_ZERO);
    for (int i = 0; i < 16; i++) cyc("wrap_add", 6'b000000, 6'b100000, 1'b0, 1'b0, C_ADD);
    chk("cnt_wrap", {28'd0, instr_count}, 32'd0);
    for (int i = 0; i < 3; i++) cyc("pre_lw_add", 6'b000000, 6'b100000, 1'b0, 1'b0, C_ADD);

    // Asynchronous reset in the middle of a lw
    cyc("lw2_exec", 6'b100011, 6'h00, 1'b0, 1'b0, C_LSEX);
    opcode = 6'b100011; mem_ack = 1'b0;
    #1;
    chk("lw2_wait", {17'd0, ctl}, {17'd0, C_LWWT});
    chk("lw2_cnt", {28'd0, instr_count}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_ctl", {17'd0, ctl}, {17'd0, C_ZERO});
    chk("arst_cnt", {28'd0, instr_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc("arst_idle", 6'b000000, 6'b100000, 1'b0, 1'b1, C_ZERO);
    cyc("arst_start", 6'b000000, 6'b100000, 1'b1, 1'b0, C_ZERO);
    cyc("arst_add", 6'b000000, 6'b100000, 1'b0, 1'b0, C_ADD);
    chk("arst_cnt1", {28'd0, instr_count}, 32'd1);

`ifdef MIPS_SEQ_CTRL_MEM_TIMEOUT_EN
    // Watchdog expiry with no ack
    do_reset();
    cyc("t_start", 6'h00, 6'h00, 1'b1, 1'b0, C_ZERO);
    cyc("t_sw_exec", 6'b101011, 6'h00, 1'b0, 1'b0, C_LSEX);
    for (int i = 0; i < 4; i++) cyc("t_wait", 6'b101011, 6'h00, 1'b0, 1'b0, C_SWWT);
    cyc("t_halt", 6'b101011, 6'h00, 1'b0, 1'b1, 15'b0_0_0_0_0_0_0_000_0_0_1_0_1);
    chk("t_cnt", {28'd0, instr_count}, 32'd0);
    // Ack on the expiry cycle completes normally
    do_reset();
    cyc("t2_start", 6'h00, 6'h00, 1'b1, 1'b0, C_ZERO);
    cyc("t2_sw_exec", 6'b101011, 6'h00, 1'b0, 1'b0, C_LSEX);
    for (int i = 0; i < 3; i++) cyc("t2_wait", 6'b101011, 6'h00, 1'b0, 1'b0, C_SWWT);
    cyc("t2_ack", 6'b101011, 6'h00, 1'b0, 1'b1, C_SWACK);
    cyc("t2_j", 6'b000010, 6'h00, 1'b0, 1'b0, C_J);
    chk("t2_cnt", {28'd0, instr_count}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
